// File: rtl/ram_arb_pkg.sv
// Shared constants and response-queue entry type for the RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned DATA_W_DEFAULT = 16;
  localparam int unsigned NUM_REQ_MAX    = 8;
  // Id field sized for the largest supported requester count so one entry type serves every build.
  localparam int unsigned IDW            = $clog2(NUM_REQ_MAX);

  typedef struct packed {
    logic [IDW-1:0]            id;
    logic [DATA_W_DEFAULT-1:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/ram_port_arbiter_rr_find_first.sv
// Round-robin pick: first set bit of mask at or after start, wrapping at N.
module rr_find_first #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    int unsigned pos;
    pos   = 0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(start) + k) % N;
      if (!found && mask[IW'(pos)]) begin
        found = 1'b1;
        idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one ram8b (1 write, 2 combinational read ports) among NUM_REQ requesters.
// One write and up to two reads granted per cycle; read data returns over a shared bus.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = DATA_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      ram_wr,
  output logic [ADDR_W-1:0]         ram_wr_addr,
  output logic [DATA_W-1:0]         ram_d_in,
  output logic [ADDR_W-1:0]         ram_rd_addr_a,
  output logic [ADDR_W-1:0]         ram_rd_addr_b,
  input  logic [DATA_W-1:0]         ram_d_out_a,
  input  logic [DATA_W-1:0]         ram_d_out_b
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  logic [IW-1:0]      wr_ptr, rd_ptr;
  logic [NUM_REQ-1:0] wr_mask, rd_mask, rd_mask_b;
  logic               wr_found, rda_found, rdb_found;
  logic [IW-1:0]      wr_idx, rda_idx, rdb_idx;

  rsp_entry_t         q [2];
  logic [1:0]         q_cnt;
  rsp_entry_t         a_e, b_e;
  rsp_entry_t         lst [3];
  logic [1:0]         n_ent;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (32'(i) == NUM_REQ - 1) ? '0 : i + IW'(1);
  endfunction

  // Reads stall while two results are still waiting for the shared bus.
  assign wr_mask   = reset ? '0 : (req_valid & req_we);
  assign rd_mask   = (reset || q_cnt == 2'd2) ? '0 : (req_valid & ~req_we);
  assign rd_mask_b = rd_mask & ~(NUM_REQ'(1) << rda_idx);

  rr_find_first #(.N(NUM_REQ), .IW(IW)) u_find_wr (
    .mask  (wr_mask),
    .start (wr_ptr),
    .found (wr_found),
    .idx   (wr_idx)
  );

  rr_find_first #(.N(NUM_REQ), .IW(IW)) u_find_rd_a (
    .mask  (rd_mask),
    .start (rd_ptr),
    .found (rda_found),
    .idx   (rda_idx)
  );

  rr_find_first #(.N(NUM_REQ), .IW(IW)) u_find_rd_b (
    .mask  (rd_mask_b),
    .start (rd_ptr),
    .found (rdb_found),
    .idx   (rdb_idx)
  );

  always_comb begin
    req_ready = '0;
    if (wr_found)  req_ready[wr_idx]  = 1'b1;
    if (rda_found) req_ready[rda_idx] = 1'b1;
    if (rdb_found) req_ready[rdb_idx] = 1'b1;
  end

  assign ram_wr        = wr_found;
  assign ram_wr_addr   = wr_found  ? addr_arr[wr_idx]  : '0;
  assign ram_d_in      = wr_found  ? wdata_arr[wr_idx] : '0;
  assign ram_rd_addr_a = rda_found ? addr_arr[rda_idx] : '0;
  assign ram_rd_addr_b = rdb_found ? addr_arr[rdb_idx] : '0;

  // Pending results first, then this cycle's A and B; the head goes to the bus.
  always_comb begin
    a_e.id   = IDW'(rda_idx);
    a_e.data = DATA_W_DEFAULT'(ram_d_out_a);
    b_e.id   = IDW'(rdb_idx);
    b_e.data = DATA_W_DEFAULT'(ram_d_out_b);
    lst[0]   = a_e;
    lst[1]   = b_e;
    lst[2]   = b_e;
    case (q_cnt)
      2'd1: begin
        lst[0] = q[0];
        lst[1] = a_e;
        lst[2] = b_e;
      end
      2'd2: begin
        lst[0] = q[0];
        lst[1] = q[1];
        lst[2] = b_e;
      end
      default: ;
    endcase
    n_ent = q_cnt + 2'(rda_found) + 2'(rdb_found);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q_cnt     <= '0;
      q[0]      <= '0;
      q[1]      <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      if (wr_found)  wr_ptr <= next_idx(wr_idx);
      if (rda_found) rd_ptr <= next_idx(rdb_found ? rdb_idx : rda_idx);
      q[0]  <= lst[1];
      q[1]  <= lst[2];
      q_cnt <= (n_ent == 2'd0) ? 2'd0 : n_ent - 2'd1;
      if (n_ent != 2'd0) begin
        rsp_valid <= NUM_REQ'(1) << lst[0].id;
        rsp_rdata <= DATA_W'(lst[0].data);
      end else begin
        rsp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomised and directed bench for ram_port_arbiter against a queue-based reference model.
module tb_ram_port_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata, ram_d_in, ram_d_out_a, ram_d_out_b;
  logic             ram_wr;
  logic [AW-1:0]    ram_wr_addr, ram_rd_addr_a, ram_rd_addr_b;

  ram_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .ram_wr        (ram_wr),
    .ram_wr_addr   (ram_wr_addr),
    .ram_d_in      (ram_d_in),
    .ram_rd_addr_a (ram_rd_addr_a),
    .ram_rd_addr_b (ram_rd_addr_b),
    .ram_d_out_a   (ram_d_out_a),
    .ram_d_out_b   (ram_d_out_b)
  );

  always #5 clk = ~clk;

  // ram8b stand-in: combinational reads, write at the rising edge
  bit [DW-1:0] ram [0:65535];
  always @(posedge clk) if (ram_wr) ram[ram_wr_addr] <= ram_d_in;
  assign ram_d_out_a = ram[ram_rd_addr_a];
  assign ram_d_out_b = ram[ram_rd_addr_b];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct { int id; logic [DW-1:0] data; } ent_t;
  typedef struct { int id; bit we; logic [AW-1:0] addr; logic [DW-1:0] data; } op_t;

  bit [DW-1:0]   shadow [0:65535];
  ent_t          mq[$];
  int            m_wr_ptr, m_rd_ptr;
  bit            m_out_v;
  int            m_out_id;
  logic [DW-1:0] m_out_data;
  int            gw, ga, gb;

  op_t           ops[$];
  bit            d_valid [NR];
  bit            d_we    [NR];
  bit            d_wait  [NR];
  logic [AW-1:0] d_addr  [NR];
  logic [DW-1:0] d_wdata [NR];
  bit            rand_gaps;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_valid[i]             = d_valid[i];
      req_we[i]                = d_we[i];
      req_addr[i*AW +: AW]     = d_addr[i];
      req_wdata[i*DW +: DW]    = d_wdata[i];
    end
  end

  // Expected grants from the round-robin rules, then compare all outputs.
  task automatic model_check();
    logic [NR-1:0] e_ready;
    logic [AW-1:0] e_ra, e_rb;
    int            i;
    gw = -1; ga = -1; gb = -1;
    e_ready = '0; e_ra = '0; e_rb = '0;
    if (!reset) begin
      for (int k = 0; k < NR; k++) begin
        i = (m_wr_ptr + k) % NR;
        if (gw < 0 && d_valid[i] && d_we[i]) gw = i;
      end
      if (mq.size() < 2) begin
        for (int k = 0; k < NR; k++) begin
          i = (m_rd_ptr + k) % NR;
          if (d_valid[i] && !d_we[i]) begin
            if (ga < 0) ga = i;
            else if (gb < 0) gb = i;
          end
        end
      end
    end
    if (gw >= 0) e_ready[gw] = 1'b1;
    if (ga >= 0) begin e_ready[ga] = 1'b1; e_ra = d_addr[ga]; end
    if (gb >= 0) begin e_ready[gb] = 1'b1; e_rb = d_addr[gb]; end
    check("req_ready", 32'(req_ready), 32'(e_ready));
    check("ram_wr", 32'(ram_wr), 32'(gw >= 0));
    if (gw >= 0) begin
      check("ram_wr_addr", 32'(ram_wr_addr), 32'(d_addr[gw]));
      check("ram_d_in", 32'(ram_d_in), 32'(d_wdata[gw]));
    end
    check("ram_rd_addr_a", 32'(ram_rd_addr_a), 32'(e_ra));
    check("ram_rd_addr_b", 32'(ram_rd_addr_b), 32'(e_rb));
    check("rsp_valid", 32'(rsp_valid), m_out_v ? (32'd1 << m_out_id) : 32'd0);
    if (m_out_v) begin
      check("rsp_rdata", 32'(rsp_rdata), 32'(m_out_data));
      d_wait[m_out_id] = 1'b0;
    end
  endtask

  // Reads capture pre-write data; pending results leave one per cycle in order.
  task automatic model_update();
    ent_t e;
    if (reset) return;
    if (ga >= 0) begin
      e.id = ga; e.data = shadow[d_addr[ga]]; mq.push_back(e);
      d_valid[ga] = 1'b0; d_wait[ga] = 1'b1;
    end
    if (gb >= 0) begin
      e.id = gb; e.data = shadow[d_addr[gb]]; mq.push_back(e);
      d_valid[gb] = 1'b0; d_wait[gb] = 1'b1;
    end
    if (gw >= 0) begin
      shadow[d_addr[gw]] = d_wdata[gw];
      m_wr_ptr = (gw + 1) % NR;
      d_valid[gw] = 1'b0;
    end
    if (ga >= 0) m_rd_ptr = ((gb >= 0 ? gb : ga) + 1) % NR;
    if (mq.size() > 0) begin
      e = mq.pop_front();
      m_out_v = 1'b1; m_out_id = e.id; m_out_data = e.data;
    end else begin
      m_out_v = 1'b0;
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_wr_ptr = 0; m_rd_ptr = 0; m_out_v = 1'b0;
    for (int i = 0; i < NR; i++) d_wait[i] = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (!d_valid[i] && !d_wait[i] && (!rand_gaps || $urandom_range(0, 3) != 0)) begin
        for (int k = 0; k < ops.size(); k++) begin
          if (ops[k].id == i) begin
            d_valid[i] = 1'b1; d_we[i] = ops[k].we;
            d_addr[i] = ops[k].addr; d_wdata[i] = ops[k].data;
            ops.delete(k);
            break;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    model_update();
    drive();
  endtask

  function automatic bit idle();
    bit busy;
    busy = (ops.size() != 0) || (mq.size() != 0) || m_out_v;
    for (int i = 0; i < NR; i++) busy = busy || d_valid[i] || d_wait[i];
    return !busy;
  endfunction

  task automatic run_idle(input string tag, input int budget);
    int c;
    c = 0;
    drive();
    while (!idle() && c < budget) begin
      step();
      c++;
    end
    check({tag, "_drained"}, 32'(idle()), 32'd1);
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    model_reset();
    drive();
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  task automatic push_op(input int id, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    op_t o;
    o.id = id; o.we = we; o.addr = addr; o.data = data;
    ops.push_back(o);
  endtask

  initial begin
    bit granted;
    for (int i = 0; i < NR; i++) begin
      d_valid[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = '0; d_wdata[i] = '0;
    end
    rand_gaps = 1'b0;

    // Single write then read, with the write already pending during reset
    push_op(0, 1'b1, 16'h0001, 16'h1234);
    apply_reset(2);
    run_idle("wr1", 20);
    push_op(0, 1'b0, 16'h0001, 16'h0000);
    run_idle("rd1", 20);

    // Write round-robin from reset
    apply_reset(1);
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < NR; i++) push_op(i, 1'b1, AW'(16'h0100 + i * 4 + j), DW'($urandom));
    run_idle("wr_rr", 50);

    // Dual read in one cycle
    push_op(0, 1'b1, 16'h0000, 16'hABCD);
    run_idle("preload", 20);
    push_op(1, 1'b0, 16'h0000, 16'h0000);
    push_op(2, 1'b0, 16'h0001, 16'h0000);
    run_idle("dual_rd", 20);

    // Same-cycle write and read to one address, then a later read
    push_op(0, 1'b1, 16'h8000, 16'h5678);
    push_op(3, 1'b0, 16'h8000, 16'h0000);
    run_idle("hazard", 20);
    push_op(1, 1'b0, 16'h8000, 16'h0000);
    run_idle("after_hazard", 20);

    // Queue full: every requester reading back-to-back
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < NR; i++) push_op(i, 1'b1, AW'(16'h0200 + i * 3 + j), DW'($urandom));
    run_idle("qf_fill", 50);
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < NR; i++) push_op(i, 1'b0, AW'(16'h0200 + i * 3 + j), 16'h0000);
    run_idle("qf_read", 100);

    // Reset the cycle after a dual-read grant; responses must vanish
    push_op(1, 1'b0, 16'h0000, 16'h0000);
    push_op(2, 1'b0, 16'h0001, 16'h0000);
    drive();
    granted = 1'b0;
    for (int c = 0; c < 10 && !granted; c++) begin
      @(negedge clk);
      model_check();
      granted = (ga >= 0) && (gb >= 0);
      @(posedge clk);
      #1;
      model_update();
      if (!granted) drive();
    end
    check("reset_mid_grant_seen", 32'(granted), 32'd1);
    for (int i = NR - 1; i >= 0; i--) push_op(i, 1'b1, AW'(16'h0300 + i), DW'($urandom));
    apply_reset(3);
    run_idle("post_reset", 50);

    // Randomised traffic over a small address window
    rand_gaps = 1'b1;
    for (int n = 0; n < 300; n++)
      push_op($urandom_range(0, NR - 1), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
    run_idle("random", 20000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
